cva6_hpdcache_req_buffer: RTL
=============================

// Module: cva6_hpdcache_req_buffer
// PURPOSE
//  Elastic request buffer between the CVA6 store/AMO port adapter and the HPDcache request port.
//  Decouples the core from cache back-pressure by queuing requests in a FIFO.
//  Bounds in-flight response-bearing requests (AMOs) with an outstanding-response counter.
//  Reports an idle status for fence/flush sequencing.
// PARAMETERS
//  REQ_WIDTH        default 128  width of packed request payload (flattened hpdcache_req_t)
//  DEPTH            default 4    FIFO entries; power of two, >= 2
//  MAX_OUTSTANDING  default 4    max issued need_rsp requests awaiting response; >= 1
// PORTS
//  clk_i            in   1          clock; all state updates on rising edge
//  rst_i            in   1          asynchronous reset, active-high
//  in_valid_i       in   1          upstream request valid
//  in_ready_o       out  1          buffer can accept a request
//  in_req_i         in   REQ_WIDTH  request payload
//  in_need_rsp_i    in   1          request expects a cache response
//  out_valid_o      out  1          request presented to HPDcache
//  out_ready_i      in   1          HPDcache accepts request
//  out_req_o        out  REQ_WIDTH  head-of-FIFO payload
//  out_need_rsp_o   out  1          head-of-FIFO need_rsp flag
//  rsp_valid_i      in   1          HPDcache returned a response for a need_rsp request
//  outstanding_o    out  $clog2(MAX_OUTSTANDING+1)  issued requests awaiting response
//  idle_o           out  1          FIFO empty and outstanding_o == 0
//  err_o            out  1          sticky: response received with nothing outstanding
// BEHAVIOUR
//  Reset:
//   - Asserting rst_i at any time empties the FIFO, whether idle or mid-transfer.
//   - It also clears the counter and err_o.
//   - Output values under reset: in_ready_o=1, out_valid_o=0, out_req_o=0, out_need_rsp_o=0,
//     outstanding_o=0, idle_o=1, err_o=0.
//   - In-flight requests are dropped without notice.
//  FIFO:
//   - Circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH.
//   - The count register is $clog2(DEPTH+1) bits.
//   - Push when in_valid_i & in_ready_o. Pop when out_valid_o & out_ready_i.
//   - in_ready_o = (count != DEPTH), decoded from registers only.
//   - There is no combinational path from out_ready_i to in_ready_o. When full, a same-cycle pop
//     does not enable a push.
//   - Simultaneous push and pop when not full or empty: count is unchanged and both pointers advance.
//   - No bypass: a request accepted in cycle N is at the earliest on out_valid_o in cycle N+1.
//   - out_req_o and out_need_rsp_o come from the head entry. They must be 0 when empty.
//   - Order is strictly FIFO; stores and AMOs are never reordered.
//  Outstanding gating:
//   - out_valid_o = (count != 0) & !(out_need_rsp_o & outstanding_o == MAX_OUTSTANDING).
//   - A blocked need_rsp head also blocks every younger store (head-of-line, intentional).
//   - Once asserted, out_valid_o holds with a stable payload until the handshake.
//   - Gating only changes out_valid_o after a response.
//  Counter:
//   - inc = pop & out_need_rsp_o; dec = rsp_valid_i & (outstanding_o != 0).
//   - inc & dec in the same cycle: the counter is unchanged.
//   - A response in the same cycle as a counter at MAX lets the head issue in the next cycle, not the same one.
//   - rsp_valid_i with outstanding_o == 0: the counter stays 0, err_o sets and holds until reset.
//   - The counter never exceeds MAX_OUTSTANDING.
//  idle_o: combinational from registers, (count == 0) & (outstanding_o == 0).
// TESTING
//  1. Reset check: pulse rst_i mid-stream with 3 entries queued.
//     -> Next cycle: in_ready_o=1, out_valid_o=0, idle_o=1, outstanding_o=0.
//  2. Fill and ordering: DEPTH=4, push A,B,C,D with out_ready_i=0.
//     -> in_ready_o=0 after D; a 5th push is refused.
//     -> Release out_ready_i: out A,B,C,D in order, one per cycle; in_ready_o=1 the cycle after the first pop.
//  3. Streaming: continuous push/pop with out_ready_i=1.
//     -> Throughput 1/cycle after 1-cycle latency; count stays 1.
//     -> Pointers wrap after 4 entries with no data corruption.
//  4. Outstanding limit: MAX_OUTSTANDING=2, queue 3 need_rsp AMOs then 1 store, no responses.
//     -> 2 AMOs issue; outstanding_o=2; out_valid_o=0 with the 3rd AMO at head; the store does not issue.
//     -> One rsp_valid_i -> outstanding_o=1; the AMO issues the next cycle, then the store.
//  5. Simultaneous inc/dec: pop a need_rsp entry in the same cycle as rsp_valid_i with outstanding_o=1.
//     -> outstanding_o stays 1; idle_o=0.
//  6. Spurious response: rsp_valid_i with outstanding_o=0.
//     -> err_o=1 and sticky; outstanding_o stays 0; only rst_i clears err_o.

Source files
------------

// File: rtl/cva6_hpdcache_req_buffer.sv
// cva6_hpdcache_req_buffer: FIFO request buffer to HPDcache with outstanding-response limiting
module cva6_hpdcache_req_buffer #(
  parameter int REQ_WIDTH       = 128,
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [REQ_WIDTH-1:0]                 in_req_i,
  input  logic                                 in_need_rsp_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [REQ_WIDTH-1:0]                 out_req_o,
  output logic                                 out_need_rsp_o,
  input  logic                                 rsp_valid_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 idle_o,
  output logic                                 err_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [OW-1:0] OMAX = OW'(MAX_OUTSTANDING);
  logic [REQ_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]     need_q;
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 empty, push, pop, inc, dec;
  always_comb begin
    empty          = count == '0;
    in_ready_o     = count != FULL;
    out_req_o      = empty ? '0 : mem_q[rd_ptr];
    out_need_rsp_o = !empty && need_q[rd_ptr];
    out_valid_o    = !empty && !(out_need_rsp_o && outstanding_o == OMAX);
    idle_o         = empty && outstanding_o == '0;
    push           = in_valid_i && in_ready_o;
    pop            = out_valid_o && out_ready_i;
    inc            = pop && out_need_rsp_o;
    dec            = rsp_valid_i && outstanding_o != '0;
  end
  // payload storage needs no reset: out_req_o is masked while empty
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr]  <= in_req_i;
      need_q[wr_ptr] <= in_need_rsp_i;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      outstanding_o <= '0;
      err_o         <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count         <= count + CW'(push) - CW'(pop);
      outstanding_o <= outstanding_o + OW'(inc) - OW'(dec);
      if (rsp_valid_i && outstanding_o == '0) err_o <= 1'b1;
    end
  end
endmodule
